// File: rtl/uart_tx_dev.sv
// Bus-mapped 8N1 console transmitter: registered single-cycle bus response, TX FIFO, level TX-empty irq.
// Bus never stalls: a TXDATA write into a full FIFO is dropped with err_o; tx_o goes low 2 edges after the first push.
module uart_tx_dev #(
   parameter int          FifoDepth    = 8,
   parameter logic [15:0] ClkDivReset  = 16'd15,
   parameter int          DataWidth    = 32,
   parameter int          AddressWidth = 32
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    req_i,
   input  logic                    we_i,
   input  logic [3:0]              be_i,
   input  logic [AddressWidth-1:0] addr_i,
   input  logic [DataWidth-1:0]    wdata_i,
   output logic                    rvalid_o,
   output logic [DataWidth-1:0]    rdata_o,
   output logic                    err_o,
   output logic                    tx_o,
   output logic                    irq_o
);

   localparam int PtrW = $clog2(FifoDepth);
   localparam int LvlW = $clog2(FifoDepth) + 1;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t            state_q, state_d;
   logic [15:0]       clkdiv_q;
   logic              irq_en_q;
   logic [7:0]        mem [FifoDepth];
   logic [PtrW-1:0]   wptr_q, rptr_q;
   logic [LvlW-1:0]   level_q;
   logic [15:0]       timer_q, div_q;
   logic [2:0]        bit_q;
   logic [7:0]        shreg_q;
   logic              tx_q, irq_q;
   logic              rvalid_q, err_q;
   logic [DataWidth-1:0] rdata_q, rdata_d;

   logic [7:0] word;
   logic       sel_tx, sel_status, sel_clkdiv, sel_ctrl, mapped;
   logic       wr, rd, full, empty, busy, push, pop, tick, err_d;

   logic unused_bits;
   assign unused_bits = ^{addr_i[AddressWidth-1:10], addr_i[1:0], wdata_i[DataWidth-1:16], be_i[3:2]};

   assign word       = addr_i[9:2];
   assign sel_tx     = (word == 8'd0);
   assign sel_status = (word == 8'd1);
   assign sel_clkdiv = (word == 8'd2);
   assign sel_ctrl   = (word == 8'd3);
   assign mapped     = sel_tx | sel_status | sel_clkdiv | sel_ctrl;
   assign wr         = req_i & we_i;
   assign rd         = req_i & ~we_i;

   assign full  = (level_q == LvlW'(FifoDepth));
   assign empty = (level_q == '0);
   assign busy  = (state_q != IDLE);
   assign tick  = (timer_q == 16'd0);

   // full is the pre-pop view, so a push colliding with a pop while full is still refused
   assign push  = wr & sel_tx & be_i[0] & ~full;
   assign err_d = req_i & (~mapped | (we_i & sel_status) | (we_i & sel_tx & be_i[0] & full));

   always_comb begin
      rdata_d = '0;
      if (rd) begin
         if (sel_status) begin
            rdata_d[15:8] = 8'(level_q);
            rdata_d[2]    = busy;
            rdata_d[1]    = empty;
            rdata_d[0]    = full;
         end else if (sel_clkdiv) begin
            rdata_d[15:0] = clkdiv_q;
         end else if (sel_ctrl) begin
            rdata_d[0] = irq_en_q;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
         clkdiv_q <= ClkDivReset;
         irq_en_q <= 1'b0;
      end else begin
         rvalid_q <= req_i;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
         if (wr && sel_clkdiv) begin
            if (be_i[0]) clkdiv_q[7:0]  <= wdata_i[7:0];
            if (be_i[1]) clkdiv_q[15:8] <= wdata_i[15:8];
         end
         if (wr && sel_ctrl && be_i[0]) irq_en_q <= wdata_i[0];
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) mem[wptr_q] <= wdata_i[7:0];
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
      end else begin
         if (push) wptr_q <= wptr_q + PtrW'(1);
         if (pop)  rptr_q <= rptr_q + PtrW'(1);
         case ({push, pop})
            2'b10:   level_q <= level_q + LvlW'(1);
            2'b01:   level_q <= level_q - LvlW'(1);
            default: level_q <= level_q;
         endcase
      end
   end

   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      case (state_q)
         IDLE: begin
            if (!empty) begin
               state_d = START;
               pop     = 1'b1;
            end
         end
         START: if (tick) state_d = DATA;
         DATA:  if (tick && bit_q == 3'd7) state_d = STOP;
         STOP: begin
            if (tick) begin
               if (!empty) begin
                  state_d = START;
                  pop     = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         timer_q <= 16'd0;
         div_q   <= 16'd0;
         bit_q   <= 3'd0;
         shreg_q <= 8'd0;
         tx_q    <= 1'b1;
         irq_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         // a pop starts a frame: the divider is frozen here so CLKDIV writes only hit later frames
         if (pop) begin
            shreg_q <= mem[rptr_q];
            div_q   <= clkdiv_q;
            timer_q <= clkdiv_q;
            bit_q   <= 3'd0;
         end else if (state_q != IDLE) begin
            if (tick) begin
               timer_q <= div_q;
               if (state_q == DATA) bit_q <= bit_q + 3'd1;
            end else begin
               timer_q <= timer_q - 16'd1;
            end
         end
         case (state_q)
            START:   tx_q <= 1'b0;
            DATA:    tx_q <= shreg_q[bit_q];
            default: tx_q <= 1'b1;
         endcase
         irq_q <= irq_en_q & empty & (state_q == IDLE);
      end
   end

   assign rvalid_o = rvalid_q;
   assign rdata_o  = rdata_q;
   assign err_o    = err_q;
   assign tx_o     = tx_q;
   assign irq_o    = irq_q;

endmodule

// File: tb/tb_uart_tx_dev.sv
// Bench for uart_tx_dev: bus-level tests plus a serial-line monitor scoring frames against a queue of expected bytes.
module tb_uart_tx_dev;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req, we;
   logic [3:0]  be;
   logic [31:0] addr, wdata;
   logic        rvalid, err, tx, irq;
   logic [31:0] rdata;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int cur_div = 15;
   logic [7:0] exp_q[$];
   int starts[$];

   uart_tx_dev #(.FifoDepth(8), .ClkDivReset(16'd15), .DataWidth(32), .AddressWidth(32)) dut (
      .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we), .be_i(be), .addr_i(addr),
      .wdata_i(wdata), .rvalid_o(rvalid), .rdata_o(rdata), .err_o(err), .tx_o(tx), .irq_o(irq)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // serial monitor: samples each bit in the middle of its period, on the falling clock edge
   initial begin
      logic prev_tx, in_frame, bad_start, stop_bit;
      logic [7:0] rx, e;
      int cnt, per, idx;
      prev_tx = 1'b1; in_frame = 1'b0; cnt = 0; per = 1; bad_start = 1'b0; rx = 8'h00;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            in_frame = 1'b0;
         end else begin
            if (!in_frame && prev_tx && !tx) begin
               in_frame = 1'b1; cnt = 0; per = cur_div + 1;
               starts.push_back(cyc);
            end else if (in_frame) begin
               cnt++;
            end
            if (in_frame && (cnt % per) == per / 2) begin
               idx = cnt / per;
               if (idx == 0) bad_start = tx;
               else if (idx <= 8) rx[idx-1] = tx;
               else begin
                  stop_bit = tx;
                  in_frame = 1'b0;
                  checks++;
                  if (exp_q.size() == 0) begin
                     failures++;
                     $display("FAIL serial_frame: unexpected frame byte=%02h", rx);
                  end else begin
                     e = exp_q.pop_front();
                     if ({bad_start, stop_bit, rx} !== {1'b0, 1'b1, e}) begin
                        failures++;
                        $display("FAIL serial_frame: got start=%b data=%02h stop=%b, want start=0 data=%02h stop=1",
                                 bad_start, rx, stop_bit, e);
                     end
                  end
               end
            end
         end
         prev_tx = tx;
      end
   end

   task automatic bus(input logic w, input logic [3:0] b, input logic [31:0] a, input logic [31:0] d,
                      output logic v, output logic [31:0] r, output logic er);
      req = 1'b1; we = w; be = b; addr = a; wdata = d;
      @(posedge clk); #1;
      v = rvalid; r = rdata; er = err;
      req = 1'b0; we = 1'b0; be = 4'h0; addr = 32'h0; wdata = 32'h0;
   endtask

   task automatic drain(input int maxc);
      int n = 0;
      while (exp_q.size() != 0 && n < maxc) begin
         @(posedge clk); n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain_timeout: %0d frames still pending, want 0", exp_q.size());
      end
      repeat (2 * (cur_div + 1) + 4) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic v, er; logic [31:0] r;
      rst_n = 1'b0; req = 1'b0; we = 1'b0; be = 4'h0; addr = 32'h0; wdata = 32'h0;
      #22;
      checks++;
      if ({tx, irq, rvalid, err, rdata} !== {1'b1, 1'b0, 1'b0, 1'b0, 32'h0}) begin
         failures++;
         $display("FAIL reset_outputs: tx=%b irq=%b rvalid=%b err=%b rdata=%h, want 1 0 0 0 0", tx, irq, rvalid, err, rdata);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
      bus(1'b0, 4'hF, 32'h4, 32'h0, v, r, er);
      checks++;
      if ({v, er, r} !== {1'b1, 1'b0, 32'h00000002}) begin
         failures++;
         $display("FAIL reset_status: vld=%b err=%b rdata=%h, want 1 0 00000002", v, er, r);
      end
      @(posedge clk); #1;
      checks++;
      if ({rvalid, err, rdata, tx, irq} !== {1'b0, 1'b0, 32'h0, 1'b1, 1'b0}) begin
         failures++;
         $display("FAIL reset_resp_clear: rvalid=%b err=%b rdata=%h tx=%b irq=%b, want 0 0 0 1 0", rvalid, err, rdata, tx, irq);
      end
   endtask

   task automatic test_frame55();
      logic v, er; logic [31:0] r;
      logic [7:0] b55;
      logic want;
      int bad = 0;
      b55 = 8'h55;
      cur_div = 3;
      bus(1'b1, 4'b0011, 32'h8, 32'h3, v, r, er);
      exp_q.push_back(b55);
      bus(1'b1, 4'b0001, 32'h0, 32'h55, v, r, er);
      checks++;
      if ({v, er, tx} !== {1'b1, 1'b0, 1'b1}) begin
         failures++;
         $display("FAIL frame55_write: vld=%b err=%b tx=%b, want 1 0 1", v, er, tx);
      end
      @(posedge clk); #1;
      checks++;
      if (tx !== 1'b1) begin
         failures++;
         $display("FAIL frame55_latency: tx=%b one edge after write, want 1", tx);
      end
      for (int j = 0; j < 41; j++) begin
         @(posedge clk); #1;
         if (j / 4 == 0) want = 1'b0;
         else if (j / 4 <= 8) want = b55[j/4 - 1];
         else want = 1'b1;
         if (tx !== want) bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL frame55_waveform: %0d of 41 cycles wrong, want 0", bad);
      end
      drain(200);
   endtask

   task automatic test_back_to_back();
      logic v, er; logic [31:0] r;
      logic [7:0] d;
      cur_div = 0;
      bus(1'b1, 4'b0011, 32'h8, 32'h0, v, r, er);
      starts.delete();
      exp_q.push_back(8'h11);
      bus(1'b1, 4'b0001, 32'h0, 32'h11, v, r, er);
      for (int i = 0; i < 9; i++) begin
         d = 8'h20 + 8'(i);
         if (i < 8) exp_q.push_back(d);
         bus(1'b1, 4'b0001, 32'h0, {24'h0, d}, v, r, er);
         checks++;
         if ({v, er} !== {1'b1, (i == 8)}) begin
            failures++;
            $display("FAIL b2b_write%0d: vld=%b err=%b, want 1 %0d", i, v, er, (i == 8));
         end
      end
      bus(1'b0, 4'hF, 32'h4, 32'h0, v, r, er);
      checks++;
      if ({er, r} !== {1'b0, 32'h00000805}) begin
         failures++;
         $display("FAIL b2b_status_full: err=%b rdata=%h, want 0 00000805", er, r);
      end
      drain(300);
      checks++;
      if (starts.size() != 9) begin
         failures++;
         $display("FAIL b2b_frame_count: %0d frames, want 9", starts.size());
      end else begin
         int gaps = 0;
         for (int i = 1; i < 9; i++) if (starts[i] - starts[i-1] != 10) gaps++;
         checks++;
         if (gaps != 0) begin
            failures++;
            $display("FAIL b2b_contiguous: %0d frame spacings not 10 clocks, want 0", gaps);
         end
      end
   endtask

   task automatic test_errors();
      logic v, er; logic [31:0] r;
      bus(1'b1, 4'hF, 32'h10, 32'h41, v, r, er);
      checks++;
      if ({v, er, r} !== {1'b1, 1'b1, 32'h0}) begin
         failures++;
         $display("FAIL err_wr_unmapped: vld=%b err=%b rdata=%h, want 1 1 0", v, er, r);
      end
      bus(1'b0, 4'hF, 32'h3F0, 32'h0, v, r, er);
      checks++;
      if ({v, er, r} !== {1'b1, 1'b1, 32'h0}) begin
         failures++;
         $display("FAIL err_rd_unmapped: vld=%b err=%b rdata=%h, want 1 1 0", v, er, r);
      end
      bus(1'b1, 4'hF, 32'h4, 32'hFFFF_FFFF, v, r, er);
      checks++;
      if ({v, er, r} !== {1'b1, 1'b1, 32'h0}) begin
         failures++;
         $display("FAIL err_wr_status: vld=%b err=%b rdata=%h, want 1 1 0", v, er, r);
      end
      bus(1'b1, 4'b1110, 32'h0, 32'h77, v, r, er);
      checks++;
      if ({v, er} !== {1'b1, 1'b0}) begin
         failures++;
         $display("FAIL txdata_no_be0: vld=%b err=%b, want 1 0", v, er);
      end
      bus(1'b0, 4'hF, 32'h0, 32'h0, v, r, er);
      checks++;
      if ({er, r} !== {1'b0, 32'h0}) begin
         failures++;
         $display("FAIL txdata_read: err=%b rdata=%h, want 0 0", er, r);
      end
      bus(1'b0, 4'hF, 32'h4, 32'h0, v, r, er);
      checks++;
      if (r !== 32'h00000002) begin
         failures++;
         $display("FAIL err_no_push: status=%h, want 00000002", r);
      end
      bus(1'b1, 4'b0001, 32'h8, 32'h0000_FF01, v, r, er);
      bus(1'b0, 4'hF, 32'h8, 32'h0, v, r, er);
      checks++;
      if ({er, r} !== {1'b0, 32'h00000001}) begin
         failures++;
         $display("FAIL clkdiv_byte_en: err=%b clkdiv=%h, want 0 00000001", er, r);
      end
      cur_div = 1;
      repeat (30) @(posedge clk);
      #1;
   endtask

   task automatic test_irq();
      logic v, er; logic [31:0] r;
      int bad = 0;
      bus(1'b1, 4'b0001, 32'hC, 32'h1, v, r, er);
      checks++;
      if (irq !== 1'b0) begin
         failures++;
         $display("FAIL irq_lag: irq=%b at enable edge, want 0", irq);
      end
      @(posedge clk); #1;
      checks++;
      if (irq !== 1'b1) begin
         failures++;
         $display("FAIL irq_assert: irq=%b, want 1", irq);
      end
      exp_q.push_back(8'hA5);
      bus(1'b1, 4'b0001, 32'h0, 32'hA5, v, r, er);
      checks++;
      if (irq !== 1'b1) begin
         failures++;
         $display("FAIL irq_hold_at_push: irq=%b, want 1", irq);
      end
      for (int k = 0; k < 21; k++) begin
         @(posedge clk); #1;
         if (irq !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL irq_low_during_frame: %0d of 21 cycles high, want 0", bad);
      end
      @(posedge clk); #1;
      checks++;
      if (irq !== 1'b1) begin
         failures++;
         $display("FAIL irq_reassert: irq=%b after frame, want 1", irq);
      end
      drain(100);
   endtask

   task automatic test_reset_mid_frame();
      logic v, er; logic [31:0] r;
      int bad = 0;
      cur_div = 7;
      bus(1'b1, 4'b0011, 32'h8, 32'h7, v, r, er);
      bus(1'b1, 4'b0001, 32'h0, 32'hFF, v, r, er);
      bus(1'b1, 4'b0001, 32'h0, 32'hFF, v, r, er);
      repeat (14) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({tx, irq, rvalid} !== {1'b1, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL async_reset: tx=%b irq=%b rvalid=%b, want 1 0 0", tx, irq, rvalid);
      end
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b1;
      cur_div = 15;
      @(posedge clk); #1;
      bus(1'b0, 4'hF, 32'h4, 32'h0, v, r, er);
      checks++;
      if ({er, r} !== {1'b0, 32'h00000002}) begin
         failures++;
         $display("FAIL reset_flush_status: err=%b status=%h, want 0 00000002", er, r);
      end
      bus(1'b0, 4'hF, 32'h8, 32'h0, v, r, er);
      checks++;
      if ({er, r} !== {1'b0, 32'h0000000F}) begin
         failures++;
         $display("FAIL reset_clkdiv: err=%b clkdiv=%h, want 0 0000000F", er, r);
      end
      for (int k = 0; k < 200; k++) begin
         @(posedge clk); #1;
         if (tx !== 1'b1) bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL no_resume: tx low %0d cycles after reset, want 0", bad);
      end
   endtask

   initial begin
      test_reset();
      test_frame55();
      test_back_to_back();
      test_errors();
      test_irq();
      test_reset_mid_frame();
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL leftover_expected: %0d frames never seen, want 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
